// File: rtl/bcd_count_sequencer_pkg.sv
// Shared types, constants and helpers for the BCD count sequencer.
package bcd_seq_pkg;

  typedef enum logic {
    S_STOP = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_DIGIT_MAX = 4'd9;
  localparam logic [7:0] BCD_ZERO      = 8'h00;

  function automatic logic bcd_valid(input logic [7:0] v);
    return (v[7:4] <= BCD_DIGIT_MAX) && (v[3:0] <= BCD_DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_count_sequencer_step.sv
// Combinational two-digit BCD +/-1 with digit carry/borrow (wraps 99<->00).
module bcd_step
  import bcd_seq_pkg::*;
(
  input  logic [7:0] value,
  input  logic       dir,
  output logic [7:0] next_value
);

  bcd_digit_t units, tens, units_n, tens_n;

  assign units = value[3:0];
  assign tens  = value[7:4];

  always_comb begin
    units_n = units;
    tens_n  = tens;
    if (!dir) begin
      if (units >= BCD_DIGIT_MAX) begin
        units_n = '0;
        tens_n  = (tens >= BCD_DIGIT_MAX) ? '0 : tens + 4'd1;
      end else begin
        units_n = units + 4'd1;
      end
    end else begin
      if (units == '0) begin
        units_n = BCD_DIGIT_MAX;
        tens_n  = (tens == '0) ? BCD_DIGIT_MAX : tens - 4'd1;
      end else begin
        units_n = units - 4'd1;
      end
    end
  end

  assign next_value = {tens_n, units_n};

endmodule

// File: rtl/bcd_count_sequencer.sv
// Run/direction/bounce controller for the 2-digit BCD display counter.
// Optional build macro BCD_SEQ_AUTO_STOP_EN: hold and stop at a bound instead of wrapping.
module bcd_count_sequencer
  import bcd_seq_pkg::*;
#(
  parameter logic [7:0] TOP_VALUE   = 8'h99,
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  logic       CLOCK_50_I,
  input  logic       RESET_I,
  input  logic       tick_i,
  input  logic       run_stop_i,
  input  logic       up_i,
  input  logic       down_i,
  input  logic       bounce_i,
  input  logic       load_i,
  input  logic [7:0] load_value_i,
  output logic [7:0] count_o,
  output logic       running_o,
  output logic       dir_o,
  output logic       bounce_en_o,
  output logic       wrap_o,
  output logic       load_err_o
);

  state_t     state, state_nxt;
  logic       dir_q, dir_nxt;
  logic       bounce_q, bounce_nxt;
  logic       wrap_q, wrap_nxt;
  logic       err_q, err_nxt;
  logic [7:0] count_q, count_nxt;
  logic [7:0] step_val, top_m1;
  logic       step_en, at_bound, load_ok;

  bcd_step u_step (
    .value      (count_q),
    .dir        (dir_q),
    .next_value (step_val)
  );

  bcd_step u_top_m1 (
    .value      (TOP_VALUE),
    .dir        (1'b1),
    .next_value (top_m1)
  );

  // Load wins over tick, so a step only happens on a tick without a load.
  assign step_en  = tick_i && !load_i && (state == S_RUN);
  assign at_bound = dir_q ? (count_q == BCD_ZERO) : (count_q == TOP_VALUE);
  assign load_ok  = bcd_valid(load_value_i) && (load_value_i <= TOP_VALUE);

  always_ff @(posedge CLOCK_50_I) begin
    if (RESET_I) state <= S_RUN;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (run_stop_i) state_nxt = (state == S_RUN) ? S_STOP : S_RUN;
`ifdef BCD_SEQ_AUTO_STOP_EN
    if (step_en && at_bound && !bounce_q) state_nxt = S_STOP;
`endif
  end

  always_comb begin
    running_o = (state == S_RUN);
  end

  always_comb begin
    count_nxt  = count_q;
    dir_nxt    = dir_q;
    bounce_nxt = bounce_q ^ bounce_i;
    wrap_nxt   = 1'b0;
    err_nxt    = 1'b0;
    if (up_i && !down_i)      dir_nxt = 1'b0;
    else if (down_i && !up_i) dir_nxt = 1'b1;

    if (load_i) begin
      if (load_ok) count_nxt = load_value_i;
      else         err_nxt   = 1'b1;
    end else if (step_en) begin
      if (!at_bound) begin
        count_nxt = step_val;
      end else begin
        wrap_nxt = 1'b1;
        // Bounce reversal is assigned last so it overrides same-cycle up/down pulses.
        if (bounce_q) begin
          count_nxt = dir_q ? (BCD_ZERO + 8'd1) : top_m1;
          dir_nxt   = !dir_q;
        end else begin
`ifdef BCD_SEQ_AUTO_STOP_EN
          count_nxt = count_q;
`else
          count_nxt = dir_q ? TOP_VALUE : BCD_ZERO;
`endif
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (RESET_I) begin
      count_q  <= RESET_VALUE;
      dir_q    <= 1'b0;
      bounce_q <= 1'b0;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      count_q  <= count_nxt;
      dir_q    <= dir_nxt;
      bounce_q <= bounce_nxt;
      wrap_q   <= wrap_nxt;
      err_q    <= err_nxt;
    end
  end

  assign count_o     = count_q;
  assign dir_o       = dir_q;
  assign bounce_en_o = bounce_q;
  assign wrap_o      = wrap_q;
  assign load_err_o  = err_q;

endmodule

// File: tb/tb_bcd_count_sequencer.sv
// Scoreboard bench for bcd_count_sequencer; a decimal-integer reference model predicts each cycle.
module tb_bcd_count_sequencer;

  logic       CLOCK_50_I = 1'b0;
  logic       RESET_I = 1'b0;
  logic       tick_i = 1'b0, run_stop_i = 1'b0, up_i = 1'b0, down_i = 1'b0;
  logic       bounce_i = 1'b0, load_i = 1'b0;
  logic [7:0] load_value_i = 8'h00;
  logic [7:0] count_o;
  logic       running_o, dir_o, bounce_en_o, wrap_o, load_err_o;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    logic [7:0] count;
    logic       running, dir, bounce, wrap, lerr;
  } exp_t;

  exp_t sb[$];

  int m_cnt;
  bit m_run, m_dir, m_bnc, m_wrap, m_lerr;
  localparam int TOP_DEC = 99;

  bcd_count_sequencer #(.TOP_VALUE(8'h99), .RESET_VALUE(8'h00)) dut (
    .CLOCK_50_I   (CLOCK_50_I),
    .RESET_I      (RESET_I),
    .tick_i       (tick_i),
    .run_stop_i   (run_stop_i),
    .up_i         (up_i),
    .down_i       (down_i),
    .bounce_i     (bounce_i),
    .load_i       (load_i),
    .load_value_i (load_value_i),
    .count_o      (count_o),
    .running_o    (running_o),
    .dir_o        (dir_o),
    .bounce_en_o  (bounce_en_o),
    .wrap_o       (wrap_o),
    .load_err_o   (load_err_o)
  );

  always #10 CLOCK_50_I = ~CLOCK_50_I;

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: advances one clock with the given inputs and queues the prediction.
  task automatic model(input bit rst, input bit tk, input bit rs, input bit up, input bit dn,
                       input bit bn, input bit ld, input logic [7:0] lv);
    int  ncnt;
    bit  nrun, ndir;
    exp_t e;
    if (rst) begin
      m_cnt = 0; m_run = 1; m_dir = 0; m_bnc = 0; m_wrap = 0; m_lerr = 0;
    end else begin
      ncnt = m_cnt; nrun = rs ? !m_run : m_run;
      ndir = m_dir;
      if (up && !dn) ndir = 0;
      if (dn && !up) ndir = 1;
      m_wrap = 0; m_lerr = 0;
      if (ld) begin
        if (lv[7:4] <= 9 && lv[3:0] <= 9 && from_bcd(lv) <= TOP_DEC) ncnt = from_bcd(lv);
        else m_lerr = 1;
      end else if (tk && m_run) begin
        if (!m_dir && m_cnt == TOP_DEC) begin
          m_wrap = 1;
          if (m_bnc) begin ncnt = TOP_DEC - 1; ndir = 1; end
`ifdef BCD_SEQ_AUTO_STOP_EN
          else nrun = 0;
`else
          else ncnt = 0;
`endif
        end else if (m_dir && m_cnt == 0) begin
          m_wrap = 1;
          if (m_bnc) begin ncnt = 1; ndir = 0; end
`ifdef BCD_SEQ_AUTO_STOP_EN
          else nrun = 0;
`else
          else ncnt = TOP_DEC;
`endif
        end else begin
          ncnt = m_dir ? m_cnt - 1 : m_cnt + 1;
        end
      end
      m_cnt = ncnt; m_run = nrun; m_dir = ndir; m_bnc = m_bnc ^ bn;
    end
    e.count = to_bcd(m_cnt); e.running = m_run; e.dir = m_dir;
    e.bounce = m_bnc; e.wrap = m_wrap; e.lerr = m_lerr;
    sb.push_back(e);
  endtask

  task automatic step(input bit rst, input bit tk, input bit rs, input bit up, input bit dn,
                      input bit bn, input bit ld, input logic [7:0] lv);
    exp_t e;
    RESET_I = rst; tick_i = tk; run_stop_i = rs; up_i = up; down_i = dn;
    bounce_i = bn; load_i = ld; load_value_i = lv;
    model(rst, tk, rs, up, dn, bn, ld, lv);
    @(posedge CLOCK_50_I);
    #1;
    RESET_I = 0; tick_i = 0; run_stop_i = 0; up_i = 0; down_i = 0;
    bounce_i = 0; load_i = 0; load_value_i = 8'h00;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $error("FAIL scoreboard: observed empty queue expected entry");
    end else begin
      e = sb.pop_front();
      chk("count",   count_o,            e.count);
      chk("running", {7'd0, running_o},  {7'd0, e.running});
      chk("dir",     {7'd0, dir_o},      {7'd0, e.dir});
      chk("bounce",  {7'd0, bounce_en_o},{7'd0, e.bounce});
      chk("wrap",    {7'd0, wrap_o},     {7'd0, e.wrap});
      chk("lerr",    {7'd0, load_err_o}, {7'd0, e.lerr});
    end
  endtask

  task automatic tick();               step(0,1,0,0,0,0,0,8'h00); endtask
  task automatic idle();               step(0,0,0,0,0,0,0,8'h00); endtask
  task automatic load(input logic [7:0] v); step(0,0,0,0,0,0,1,v); endtask

  initial begin
    @(posedge CLOCK_50_I); #1;
    step(1,0,0,0,0,0,0,8'h00);
    chk("rst_count", count_o, 8'h00);
    chk("rst_run", {7'd0, running_o}, 8'h01);

    for (int i = 0; i < 12; i++) tick();
    chk("seq12", count_o, 8'h12);

    load(8'h98); tick(); tick();
`ifndef BCD_SEQ_AUTO_STOP_EN
    chk("wrap_top", count_o, 8'h00);
`endif
    step(0,0,0,0,0,1,0,8'h00);
    if (!running_o) step(0,0,1,0,0,0,0,8'h00);
    load(8'h98); tick(); tick();
    chk("bounce_top", count_o, 8'h98);
    chk("bounce_dir", {7'd0, dir_o}, 8'h01);

    step(0,0,0,0,0,1,0,8'h00);
    load(8'h00); tick();
`ifndef BCD_SEQ_AUTO_STOP_EN
    chk("wrap_bot", count_o, 8'h99);
`endif
    if (!running_o) step(0,0,1,0,0,0,0,8'h00);
    step(0,0,0,0,1,1,0,8'h00);
    load(8'h00); tick();
    chk("bounce_bot", count_o, 8'h01);
    step(0,0,0,0,1,0,0,8'h00);
    step(0,1,0,1,0,0,0,8'h00);         // bounce reversal vs same-cycle up pulse
    load(8'h00); step(0,1,0,0,0,0,0,8'h00);

    load(8'h40);
    step(0,0,1,0,0,0,0,8'h00);
    for (int i = 0; i < 5; i++) tick();
    chk("frozen", count_o, 8'h40);
    step(0,0,1,0,0,0,0,8'h00);
    tick();

    load(8'h3A); idle(); load(8'hA0); idle();
    step(0,1,0,0,0,0,1,8'h55);
    chk("load_wins", count_o, 8'h55);
    step(0,1,1,0,0,0,0,8'h00);          // tick uses pre-toggle run state
    step(0,1,1,0,0,0,0,8'h00);

    step(0,0,0,1,1,0,0,8'h00);
    step(0,0,0,0,1,0,0,8'h00);
    step(0,0,0,1,1,0,0,8'h00);
    step(0,0,0,1,0,0,0,8'h00);
    step(0,0,0,0,0,1,0,8'h00);
    step(0,0,0,0,0,1,0,8'h00);
    load(8'h99); tick(); tick();
    step(0,1,1,1,1,1,1,8'h42);
    step(1,1,1,0,1,1,1,8'h77);          // reset discards same-cycle pulses

    for (int i = 0; i < 200; i++) begin
      logic [7:0] lv;
      lv = 8'($urandom_range(0, 255));
      step(0, $urandom_range(0,3) != 0, $urandom_range(0,15) == 0,
           $urandom_range(0,15) == 0, $urandom_range(0,15) == 0,
           $urandom_range(0,15) == 0, $urandom_range(0,31) == 0, lv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_count_sequencer.md
Name: bcd_count_sequencer

Overview:
Run/direction/bounce controller for the 2-digit BCD display counter.
- Consumes the debounced button edge pulses and a 1 Hz tick enable.
- Sequences the BCD count value that feeds the seven-segment converters.
- Sits between the debounce/clock-divider logic and the hex-to-seven-segment units in the board top level.

Parameters:
- TOP_VALUE, 8'h99: upper count bound, BCD. Must be valid BCD and at least 8'h01.
- RESET_VALUE, 8'h00: count loaded on reset. Must be valid BCD and at most TOP_VALUE.

Ports:
- CLOCK_50_I  in  1  50 MHz system clock; single clock domain.
- RESET_I  in  1  synchronous, active-high reset.
- tick_i  in  1  one-cycle count-step enable (1 Hz rising edge).
- run_stop_i  in  1  one-cycle pulse; toggles run/stop.
- up_i  in  1  one-cycle pulse; selects up direction.
- down_i  in  1  one-cycle pulse; selects down direction.
- bounce_i  in  1  one-cycle pulse; toggles bounce mode.
- load_i  in  1  one-cycle pulse; load load_value_i.
- load_value_i  in  8  BCD value to load.
- count_o  out  8  current BCD count; two digits, [7:4] tens.
- running_o  out  1  1 = counting.
- dir_o  out  1  0 = up, 1 = down.
- bounce_en_o  out  1  1 = reverse at bounds instead of wrapping.
- wrap_o  out  1  one-cycle pulse on wrap or bounce reversal.
- load_err_o  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (RESET_I high at a clock edge) sets:
  - count_o = RESET_VALUE
  - state = S_RUN, so running_o = 1
  - dir_o = 0, bounce_en_o = 0
  - wrap_o = 0, load_err_o = 0
- Reset mid-operation discards any same-cycle pulses.
- FSM states:
  - S_STOP: hold count.
  - S_RUN: step count on tick_i.
  - Transitions: S_RUN <-> S_STOP on each run_stop_i pulse.
- Control registers:
  - up_i clears dir; down_i sets dir.
  - up_i and down_i in the same cycle: dir unchanged.
  - bounce_i toggles bounce_en.
- Control updates are registered. A tick in the same cycle as a control pulse uses the pre-update state/dir/bounce_en.
- Step on tick_i while in S_RUN, with no load in the same cycle. Latency is 1 cycle: count_o changes on the edge after tick_i.
  - Up, count below TOP_VALUE: BCD increment. A units digit of 9 becomes 0 and carries into tens, e.g. 19 -> 20.
  - Up, count == TOP_VALUE, bounce_en=0: count = 00, wrap_o pulses.
  - Up, count == TOP_VALUE, bounce_en=1: count = TOP_VALUE-1 (BCD), dir <- 1, wrap_o pulses.
  - Down, count above 00: BCD decrement. A units digit of 0 becomes 9 and borrows from tens, e.g. 20 -> 19.
  - Down, count == 00, bounce_en=0: count = TOP_VALUE, wrap_o pulses.
  - Down, count == 00, bounce_en=1: count = 01, dir <- 0, wrap_o pulses.
- Bounce reversal overrides a same-cycle up_i/down_i.
- Load:
  - load_i has priority over tick_i and is accepted in either state.
  - Accepted when both nibbles are at most 9 and load_value_i is at most TOP_VALUE; count_o = load_value_i on the next edge.
  - Otherwise count is unchanged and load_err_o pulses for one cycle.
- tick_i while in S_STOP: no effect.
- All outputs are registered; no combinational input-to-output paths.

Optional Feature:
- Macro BCD_SEQ_AUTO_STOP_EN.
- Defined: in non-bounce mode, reaching a bound does not wrap. Count holds at the bound, state goes to S_STOP, and wrap_o pulses.
- Undefined: wrap as specified above.
- Bounce-mode behaviour is identical in both builds.

Decomposition:
- Package bcd_seq_pkg holds:
  - state enum typedef (S_STOP, S_RUN)
  - BCD digit typedef (4-bit)
  - constants BCD_DIGIT_MAX = 4'd9 and BCD_ZERO = 8'h00
  - a BCD-valid check function
- Sub-module bcd_step: combinational 2-digit BCD +/-1 with digit carry/borrow.
  - Inputs: value, dir. Output: next value.
  - Used for the normal step and for the TOP_VALUE-1 computation.

Test Plan:
- Reset, then 12 ticks -> count_o 00,01,...,09,10,11,12; running_o=1, dir_o=0.
- Load 8'h98, 2 ticks in up, bounce_en=0 -> 99 then 00, wrap_o pulses once. Repeat with bounce_en=1 -> 99 then 98, dir_o=1, wrap_o pulses.
- Load 8'h00, dir down, 1 tick -> 99 with bounce off; with bounce on -> 01 and dir_o=0.
- run_stop_i pulse, then 5 ticks -> count frozen. Second run_stop_i, then 1 tick -> count advances by exactly 1.
- Rejected loads, load_value_i 8'h3A and 8'h A0 -> count unchanged, load_err_o one-cycle pulse each. Load together with tick -> loaded value wins, no step.
- up_i and down_i same cycle -> dir unchanged. With BCD_SEQ_AUTO_STOP_EN, count 99 up + tick -> holds 99, running_o=0.
